fc_pass_sched: RTL and testbench

- Schedules the fully-connected layer that follows 4x4 max-pooling.
- Buffers one frame of NPOS pooled vectors, each CO channels of OF_BW bits.
- Replays the frame NGRP times into the shared CO-channel FC accumulator, one pass per output-neuron group, and drives the weight-bank select for each pass.
- Collects each pass's CO accumulated sums and hands them downstream with a valid/ready handshake. Sits between the pooling stage and the FC accumulator / classifier.

---
 rtl/fc_pass_sched.sv | 145 ++++++++++++++
 tb/tb_fc_pass_sched.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_pass_sched.sv
// Frame buffer and pass scheduler for the FC layer after 4x4 max-pooling.
// One frame of pooled vectors is replayed once per output-neuron group.
module fc_pass_sched #(
  parameter int CO      = 3,
  parameter int OF_BW   = 34,
  parameter int ACC_BW  = 40,
  parameter int NPOS    = 16,
  parameter int NGRP    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_in_valid,
  output logic                       o_in_ready,
  input  logic [CO*OF_BW-1:0]        i_in_pooling,
  output logic                       o_acc_valid,
  output logic [CO*OF_BW-1:0]        o_acc_pooling,
  output logic [$clog2(NGRP)-1:0]    o_grp_sel,
  input  logic                       i_acc_valid,
  input  logic [CO*ACC_BW-1:0]       i_acc_data,
  output logic                       o_out_valid,
  input  logic                       i_out_ready,
  output logic [CO*ACC_BW-1:0]       o_out_data,
  output logic [$clog2(NGRP)-1:0]    o_out_grp,
  output logic                       o_busy,
  output logic                       o_err
);

  localparam int PW = $clog2(NPOS);
  localparam int GW = $clog2(NGRP);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int VW = CO * OF_BW;
  localparam int RW = CO * ACC_BW;

  typedef enum logic [1:0] {ST_LOAD, ST_RUN, ST_WAIT, ST_OUT} state_t;

  state_t          state, state_d;
  logic [PW-1:0]   wr_ptr, wr_ptr_d;
  logic [PW-1:0]   rd_ptr, rd_ptr_d;
  logic [GW-1:0]   grp, grp_d;
  logic [TW-1:0]   wait_cnt, wait_cnt_d;
  logic            err_d;
  logic            capture;
  logic            wr_en;
  logic [RW-1:0]   result;
  logic [VW-1:0]   frame_buf [NPOS];

  always_comb begin
    state_d    = state;
    wr_ptr_d   = wr_ptr;
    rd_ptr_d   = rd_ptr;
    grp_d      = grp;
    wait_cnt_d = '0;
    err_d      = o_err;
    capture    = 1'b0;
    wr_en      = 1'b0;
    case (state)
      ST_LOAD: begin
        if (i_in_valid) begin
          wr_en = 1'b1;
          if (wr_ptr == PW'(NPOS - 1)) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            grp_d    = '0;
            state_d  = ST_RUN;
          end else begin
            wr_ptr_d = wr_ptr + 1'b1;
          end
        end
      end
      ST_RUN: begin
        if (rd_ptr == PW'(NPOS - 1)) begin
          rd_ptr_d = '0;
          state_d  = ST_WAIT;
        end else begin
          rd_ptr_d = rd_ptr + 1'b1;
        end
      end
      ST_WAIT: begin
        if (i_acc_valid) begin
          capture = 1'b1;
          state_d = ST_OUT;
        end else if (wait_cnt == TW'(TIMEOUT - 1)) begin
          // Accumulator never answered: drop the whole frame.
          err_d    = 1'b1;
          wr_ptr_d = '0;
          grp_d    = '0;
          state_d  = ST_LOAD;
        end else begin
          wait_cnt_d = wait_cnt + 1'b1;
        end
      end
      ST_OUT: begin
        if (i_out_ready) begin
          if (grp == GW'(NGRP - 1)) begin
            grp_d   = '0;
            state_d = ST_LOAD;
          end else begin
            grp_d   = grp + 1'b1;
            state_d = ST_RUN;
          end
        end
      end
      default: state_d = ST_LOAD;
    endcase
    if (i_acc_valid && (state != ST_WAIT)) err_d = 1'b1;
  end

  // Beat outputs are launched from the next-state view so beats line up with RUN cycles.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= ST_LOAD;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      grp           <= '0;
      wait_cnt      <= '0;
      o_err         <= 1'b0;
      result        <= '0;
      o_acc_valid   <= 1'b0;
      o_acc_pooling <= '0;
    end else begin
      state       <= state_d;
      wr_ptr      <= wr_ptr_d;
      rd_ptr      <= rd_ptr_d;
      grp         <= grp_d;
      wait_cnt    <= wait_cnt_d;
      o_err       <= err_d;
      o_acc_valid <= (state_d == ST_RUN);
      if (state_d == ST_RUN) o_acc_pooling <= frame_buf[rd_ptr_d];
      if (capture) result <= i_acc_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_n && wr_en) frame_buf[wr_ptr] <= i_in_pooling;
  end

  assign o_in_ready  = (state == ST_LOAD);
  assign o_grp_sel   = grp;
  assign o_out_valid = (state == ST_OUT);
  assign o_out_data  = result;
  assign o_out_grp   = grp;
  assign o_busy      = !((state == ST_LOAD) && (wr_ptr == '0));

endmodule

// File: tb/tb_fc_pass_sched.sv
// Self-checking bench for fc_pass_sched with a stub FC accumulator and a
// result scoreboard fed from a table of expected group outputs.
module tb_fc_pass_sched;

  localparam int CO      = 3;
  localparam int OF_BW   = 34;
  localparam int ACC_BW  = 40;
  localparam int NPOS    = 16;
  localparam int NGRP    = 4;
  localparam int TIMEOUT = 64;
  localparam int ACC_LAT = 5;
  localparam int GW      = $clog2(NGRP);
  localparam int VW      = CO * OF_BW;
  localparam int RW      = CO * ACC_BW;

  typedef struct {
    logic [GW-1:0] grp;
    logic [RW-1:0] data;
  } exp_t;

  logic            clk = 1'b0;
  logic            reset_n;
  logic            i_in_valid;
  logic            o_in_ready;
  logic [VW-1:0]   i_in_pooling;
  logic            o_acc_valid;
  logic [VW-1:0]   o_acc_pooling;
  logic [GW-1:0]   o_grp_sel;
  logic            i_acc_valid = 1'b0;
  logic [RW-1:0]   i_acc_data = '0;
  logic            o_out_valid;
  logic            i_out_ready;
  logic [RW-1:0]   o_out_data;
  logic [GW-1:0]   o_out_grp;
  logic            o_busy;
  logic            o_err;

  int            checks = 0;
  int            errors = 0;
  int            outs_seen = 0;
  int            outs_target = 0;
  int            exp_pass = 0;
  logic          stub_en = 1'b1;
  logic          spur_req = 1'b0;
  exp_t          exp_tbl [NGRP];
  exp_t          sb [$];
  logic [VW-1:0] frame_vec [NPOS];

  fc_pass_sched #(
    .CO(CO), .OF_BW(OF_BW), .ACC_BW(ACC_BW),
    .NPOS(NPOS), .NGRP(NGRP), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .i_in_valid(i_in_valid), .o_in_ready(o_in_ready), .i_in_pooling(i_in_pooling),
    .o_acc_valid(o_acc_valid), .o_acc_pooling(o_acc_pooling), .o_grp_sel(o_grp_sel),
    .i_acc_valid(i_acc_valid), .i_acc_data(i_acc_data),
    .o_out_valid(o_out_valid), .i_out_ready(i_out_ready),
    .o_out_data(o_out_data), .o_out_grp(o_out_grp),
    .o_busy(o_busy), .o_err(o_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [VW-1:0] mkVec(input int v);
    logic [VW-1:0] r;
    for (int c = 0; c < CO; c++) r[c*OF_BW +: OF_BW] = OF_BW'(v);
    return r;
  endfunction

  function automatic logic [RW-1:0] accData(input logic [GW-1:0] g);
    logic [RW-1:0] r;
    for (int c = 0; c < CO; c++) r[c*ACC_BW +: ACC_BW] = ACC_BW'(100 * int'(g) + c);
    return r;
  endfunction

  task automatic applyStimulus(input logic v, input logic [VW-1:0] d);
    @(posedge clk);
    #1;
    i_in_valid   = v;
    i_in_pooling = d;
  endtask

  task automatic checkResetState();
    checkOutput("rst_acc_valid", 128'(o_acc_valid), 128'(0));
    checkOutput("rst_acc_pooling", 128'(o_acc_pooling), 128'(0));
    checkOutput("rst_grp_sel", 128'(o_grp_sel), 128'(0));
    checkOutput("rst_out_valid", 128'(o_out_valid), 128'(0));
    checkOutput("rst_out_data", 128'(o_out_data), 128'(0));
    checkOutput("rst_out_grp", 128'(o_out_grp), 128'(0));
    checkOutput("rst_busy", 128'(o_busy), 128'(0));
    checkOutput("rst_err", 128'(o_err), 128'(0));
    checkOutput("rst_in_ready", 128'(o_in_ready), 128'(1));
  endtask

  task automatic doReset();
    @(posedge clk);
    #1 reset_n = 1'b0;
    @(posedge clk);
    #1 reset_n = 1'b1;
    exp_pass = 0;
    @(negedge clk);
    checkResetState();
  endtask

  // Load NPOS vectors valued base+k+1, optionally with one idle cycle after each.
  task automatic loadFrame(input int base, input logic gap, input int spur_at, input logic push);
    for (int k = 0; k < NPOS; k++) begin
      applyStimulus(1'b1, mkVec(base + k + 1));
      frame_vec[k] = mkVec(base + k + 1);
      checkOutput("in_ready_load", 128'(o_in_ready), 128'(1));
      if (k == 1) checkOutput("busy_loading", 128'(o_busy), 128'(1));
      if (k == spur_at) spur_req = 1'b1;
      if (gap) applyStimulus(1'b0, '0);
    end
    if (!gap) applyStimulus(1'b0, '0);
    checkOutput("run_after_last_write", 128'(o_acc_valid), 128'(1));
    checkOutput("in_ready_dropped", 128'(o_in_ready), 128'(0));
    if (push) begin
      for (int g = 0; g < NGRP; g++) sb.push_back(exp_tbl[g]);
      outs_target += NGRP;
    end
  endtask

  task automatic waitOuts(input int target);
    int n = 0;
    while (outs_seen < target && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (outs_seen < target) begin
      errors++;
      checks++;
      $display("[TB] FAIL wait_results: got %0d results, expected %0d", outs_seen, target);
    end
  endtask

  // Stub accumulator: checks every beat, answers ACC_LAT cycles after the last one.
  initial begin
    int beats = 0;
    int delay = 0;
    logic pend;
    logic [GW-1:0] cap_grp = '0;
    forever begin
      @(negedge clk);
      pend = 1'b0;
      if (!reset_n) begin
        beats = 0;
        delay = 0;
      end else begin
        if (delay > 0) begin
          delay--;
          if (delay == 0) pend = 1'b1;
        end
        if (spur_req) begin
          pend = 1'b1;
          spur_req = 1'b0;
        end
        if (o_acc_valid) begin
          checkOutput("beat_data", 128'(o_acc_pooling), 128'(frame_vec[beats]));
          checkOutput("grp_sel", 128'(o_grp_sel), 128'(exp_pass));
          if (beats == 0) cap_grp = o_grp_sel;
          beats++;
          if (beats == NPOS) begin
            beats = 0;
            exp_pass = (exp_pass + 1) % NGRP;
            if (stub_en) delay = ACC_LAT;
          end
        end else if (beats != 0) begin
          checkOutput("beat_gap", 128'(o_acc_valid), 128'(1));
          beats = 0;
        end
      end
      @(posedge clk);
      #1;
      i_acc_valid = pend;
      i_acc_data  = accData(cap_grp);
    end
  end

  // Result monitor: pops the scoreboard on every transfer and checks handshake rules.
  initial begin
    logic prev_accept = 1'b0;
    logic [GW-1:0] prev_grp = '0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        prev_accept = 1'b0;
      end else begin
        if (prev_accept) begin
          if (prev_grp == GW'(NGRP - 1)) checkOutput("ready_after_last", 128'(o_in_ready), 128'(1));
          else checkOutput("run_after_accept", 128'(o_acc_valid), 128'(1));
        end
        if (o_acc_valid || o_out_valid) checkOutput("in_ready_low", 128'(o_in_ready), 128'(0));
        if (o_out_valid) checkOutput("acc_idle_in_out", 128'(o_acc_valid), 128'(0));
        prev_accept = o_out_valid && i_out_ready;
        prev_grp    = o_out_grp;
        if (o_out_valid && i_out_ready) begin
          if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected_out: got grp %0d, expected no result", o_out_grp);
          end else begin
            e = sb.pop_front();
            checkOutput("out_data", 128'(o_out_data), 128'(e.data));
            checkOutput("out_grp", 128'(o_out_grp), 128'(e.grp));
          end
          outs_seen++;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    exp_tbl[0] = '{grp: 2'd0, data: {40'd2,   40'd1,   40'd0}};
    exp_tbl[1] = '{grp: 2'd1, data: {40'd102, 40'd101, 40'd100}};
    exp_tbl[2] = '{grp: 2'd2, data: {40'd202, 40'd201, 40'd200}};
    exp_tbl[3] = '{grp: 2'd3, data: {40'd302, 40'd301, 40'd300}};

    reset_n      = 1'b0;
    i_in_valid   = 1'b0;
    i_in_pooling = '0;
    i_out_ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    @(negedge clk);
    checkResetState();

    $display("[TB] nominal frame");
    loadFrame(0, 1'b0, -1, 1'b1);
    waitOuts(outs_target);
    checkOutput("err_clean", 128'(o_err), 128'(0));

    $display("[TB] input gaps and backpressure at group 1");
    loadFrame(16, 1'b1, -1, 1'b1);
    waitOuts(outs_target - 3);
    @(posedge clk);
    #1 i_out_ready = 1'b0;
    n = 0;
    while (!o_out_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    for (int i = 0; i < 10; i++) begin
      checkOutput("stall_valid", 128'(o_out_valid), 128'(1));
      checkOutput("stall_data", 128'(o_out_data), 128'(exp_tbl[1].data));
      checkOutput("stall_grp", 128'(o_out_grp), 128'(exp_tbl[1].grp));
      @(negedge clk);
    end
    @(posedge clk);
    #1 i_out_ready = 1'b1;
    waitOuts(outs_target);

    $display("[TB] spurious accumulator pulse during load");
    loadFrame(32, 1'b0, 5, 1'b1);
    checkOutput("err_spurious", 128'(o_err), 128'(1));
    waitOuts(outs_target);

    $display("[TB] reset clears error");
    doReset();

    $display("[TB] accumulator timeout");
    stub_en = 1'b0;
    loadFrame(48, 1'b0, -1, 1'b0);
    n = 0;
    while (n < NPOS) begin
      @(negedge clk);
      if (o_acc_valid) n++;
    end
    repeat (TIMEOUT) @(negedge clk);
    checkOutput("err_before_timeout", 128'(o_err), 128'(0));
    @(negedge clk);
    checkOutput("err_at_timeout", 128'(o_err), 128'(1));
    checkOutput("ready_after_timeout", 128'(o_in_ready), 128'(1));
    checkOutput("idle_after_timeout", 128'(o_busy), 128'(0));
    @(posedge clk);
    #1;
    exp_pass = 0;
    stub_en  = 1'b1;

    $display("[TB] nominal frame after timeout");
    loadFrame(64, 1'b0, -1, 1'b1);
    waitOuts(outs_target);
    checkOutput("err_sticky", 128'(o_err), 128'(1));

    $display("[TB] reset during group 2 pass");
    loadFrame(80, 1'b0, -1, 1'b1);
    n = 0;
    while (!(o_acc_valid && o_grp_sel == 2'd2) && n < 500) begin
      @(negedge clk);
      n++;
    end
    for (int b = 1; b < 7; b++) begin
      @(negedge clk);
      checkOutput("grp2_beat", 128'(o_acc_valid), 128'(1));
    end
    doReset();
    sb.delete();
    outs_target = outs_seen;
    repeat (5) @(negedge clk);
    checkOutput("no_out_after_abort", 128'(o_out_valid), 128'(0));

    $display("[TB] fresh frame after abort");
    loadFrame(96, 1'b0, -1, 1'b1);
    waitOuts(outs_target);
    checkOutput("err_after_abort", 128'(o_err), 128'(0));

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
